// File: rtl/seq_alu_if.sv
// Handshake bundle between operand-read, the sequential ALU and write-back.
// The master side offers ops and consumes results; the slave side is the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       code;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             reg_write;

    modport master (
        output in_valid, a, b, code, out_ready,
        input  in_ready, out_valid, result, zero, reg_write
    );

    modport slave (
        input  in_valid, a, b, code, out_ready,
        output in_ready, out_valid, result, zero, reg_write
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add
// MUL and restoring DIVU/REMU, one bit per cycle, with valid/ready on both sides.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_DIVU = 4'b0110;
    localparam logic [3:0] OP_REMU = 4'b0111;
    localparam logic [3:0] OP_GT   = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       code_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] acc_reg, opa_reg, opb_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg, reg_write_reg;

    logic             accept, iter_op, last_iter;
    logic [63:0]      b_wide;
    logic             shift_big;
    logic [WIDTH-1:0] sc_result;
    logic             sc_legal;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next, quo_next, iter_result;

    assign accept    = bus.in_valid && (state_reg == IDLE);
    assign iter_op   = (bus.code == OP_MUL) || (bus.code == OP_DIVU) || (bus.code == OP_REMU);
    assign last_iter = (state_reg == BUSY) && (cnt_reg == CW'(WIDTH - 1));

    // Shift amounts use the whole of b, so anything >= WIDTH must flush to zero.
    assign b_wide    = 64'(bus.b);
    assign shift_big = b_wide >= 64'(WIDTH);

    always_comb begin
        sc_result = '0;
        sc_legal  = 1'b1;
        case (bus.code)
            OP_AND:  sc_result = bus.a & bus.b;
            OP_OR:   sc_result = bus.a | bus.b;
            OP_ADD:  sc_result = bus.a + bus.b;
            OP_SUB:  sc_result = (bus.a > bus.b) ? (bus.a - bus.b) : '0;
            OP_GT:   sc_result = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
            OP_SLL:  sc_result = shift_big ? '0 : (bus.a << bus.b[SHW-1:0]);
            OP_SRL:  sc_result = shift_big ? '0 : (bus.a >> bus.b[SHW-1:0]);
            OP_MUL, OP_DIVU, OP_REMU: sc_result = '0;
            default: sc_legal = 1'b0;
        endcase
    end

    // acc_reg is the product accumulator for MUL and the partial remainder for
    // DIVU/REMU; opa_reg shifts the dividend out while the quotient shifts in.
    always_comb begin
        mul_acc_next = opb_reg[0] ? (acc_reg + opa_reg) : acc_reg;
        rem_shift    = {acc_reg, opa_reg[WIDTH-1]};
        rem_ge       = rem_shift >= {1'b0, opb_reg};
        rem_diff     = rem_shift - {1'b0, opb_reg};
        rem_next     = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next     = {opa_reg[WIDTH-2:0], rem_ge};
        case (code_reg)
            OP_MUL:  iter_result = mul_acc_next;
            OP_DIVU: iter_result = quo_next;
            default: iter_result = rem_next;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = iter_op ? BUSY : DONE;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_reg == IDLE);
        bus.out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_reg      <= '0;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            opa_reg       <= '0;
            opb_reg       <= '0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            reg_write_reg <= 1'b0;
        end else if (accept) begin
            code_reg <= bus.code;
            cnt_reg  <= '0;
            if (iter_op) begin
                acc_reg <= '0;
                opa_reg <= bus.a;
                opb_reg <= bus.b;
            end else begin
                result_reg    <= sc_result;
                zero_reg      <= (sc_result == '0);
                reg_write_reg <= sc_legal;
            end
        end else if (state_reg == BUSY) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (code_reg == OP_MUL) begin
                acc_reg <= mul_acc_next;
                opa_reg <= opa_reg << 1;
                opb_reg <= opb_reg >> 1;
            end else begin
                acc_reg <= rem_next;
                opa_reg <= quo_next;
            end
            if (last_iter) begin
                result_reg    <= iter_result;
                zero_reg      <= (iter_result == '0);
                reg_write_reg <= 1'b1;
            end
        end
    end

    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.reg_write = reg_write_reg;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a 32-bit and an 8-bit instance share one stimulus
// driver, selected by sel8, with expected values written out by hand.
module tb_seq_alu;
    logic        clk;
    logic        rst_n;
    logic        sel8;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;

    int total = 0;
    int bad   = 0;

    seq_alu_if #(.WIDTH(32)) bus32 ();
    seq_alu_if #(.WIDTH(8))  bus8 ();

    assign bus32.in_valid  = in_valid & ~sel8;
    assign bus32.out_ready = out_ready & ~sel8;
    assign bus32.a         = a;
    assign bus32.b         = b;
    assign bus32.code      = code;
    assign bus8.in_valid   = in_valid & sel8;
    assign bus8.out_ready  = out_ready & sel8;
    assign bus8.a          = a[7:0];
    assign bus8.b          = b[7:0];
    assign bus8.code       = code;

    seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    logic        mon_in_ready, mon_out_valid, mon_zero, mon_rw;
    logic [31:0] mon_result;
    assign mon_in_ready  = sel8 ? bus8.in_ready  : bus32.in_ready;
    assign mon_out_valid = sel8 ? bus8.out_valid : bus32.out_valid;
    assign mon_zero      = sel8 ? bus8.zero      : bus32.zero;
    assign mon_rw        = sel8 ? bus8.reg_write : bus32.reg_write;
    assign mon_result    = sel8 ? {24'b0, bus8.result} : bus32.result;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          w8;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          rw;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One complete transaction: offer, wait for the result, check it, optionally
    // stall the consumer for `hold` cycles, then retire it.
    task automatic do_op(input bit w8, input logic [3:0] c, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input bit rw,
                         input string name, input bit spam, input int hold);
        int          lat, exp_lat, busy_ready;
        logic [31:0] snap;
        exp_lat = (c == 4'd5 || c == 4'd6 || c == 4'd7) ? (w8 ? 9 : 33) : 1;
        @(negedge clk);
        sel8      = w8;
        code      = c;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check({name, " in_ready"}, 32'(mon_in_ready), 32'd1);
        @(negedge clk);
        lat        = 1;
        busy_ready = 0;
        if (spam) begin
            code = 4'b0010;
            a    = $urandom;
            b    = $urandom;
        end else begin
            in_valid = 1'b0;
        end
        while (!mon_out_valid && lat < 100) begin
            busy_ready += int'(mon_in_ready);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " stall"}, 32'(busy_ready), 32'd0);
        check({name, " done_in_ready"}, 32'(mon_in_ready), 32'd0);
        check({name, " result"}, mon_result, exp);
        check({name, " zero"}, 32'(mon_zero), 32'(exp == 32'd0));
        check({name, " reg_write"}, 32'(mon_rw), 32'(rw));
        snap = mon_result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " hold_valid"}, 32'(mon_out_valid), 32'd1);
            check({name, " hold_result"}, mon_result, snap);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " retire_valid"}, 32'(mon_out_valid), 32'd0);
        check({name, " retire_ready"}, 32'(mon_in_ready), 32'd1);
        check({name, " keep_result"}, mon_result, exp);
        $display("op %-12s w8=%0d a=%h b=%h result=%h lat=%0d", name, w8, x, y, mon_result, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{1'b0, 4'b0010, 32'd7,          32'd5,          32'd12,         1'b1, "add"});
        vecs.push_back('{1'b0, 4'b0100, 32'd3,          32'd9,          32'd0,          1'b1, "sub_sat"});
        vecs.push_back('{1'b0, 4'b0100, 32'd9,          32'd3,          32'd6,          1'b1, "sub"});
        vecs.push_back('{1'b0, 4'b0000, 32'h0000F0F0,   32'h0000FF00,   32'h0000F000,   1'b1, "and"});
        vecs.push_back('{1'b0, 4'b0001, 32'h0000F0F0,   32'h00000F0F,   32'h0000FFFF,   1'b1, "or"});
        vecs.push_back('{1'b0, 4'b0010, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, "add_wrap"});
        vecs.push_back('{1'b0, 4'b1000, 32'd5,          32'd3,          32'd1,          1'b1, "gt_true"});
        vecs.push_back('{1'b0, 4'b1000, 32'd3,          32'd5,          32'd0,          1'b1, "gt_false"});
        vecs.push_back('{1'b0, 4'b0011, 32'd1,          32'd32,         32'd0,          1'b1, "sll_32"});
        vecs.push_back('{1'b0, 4'b0011, 32'd1,          32'd31,         32'h80000000,   1'b1, "sll_31"});
        vecs.push_back('{1'b0, 4'b1100, 32'h80000000,   32'd31,         32'd1,          1'b1, "srl_31"});
        vecs.push_back('{1'b0, 4'b1100, 32'hFFFFFFFF,   32'd33,         32'd0,          1'b1, "srl_33"});
        vecs.push_back('{1'b0, 4'b0101, 32'h0000FFFF,   32'h00010001,   32'hFFFFFFFF,   1'b1, "mul"});
        vecs.push_back('{1'b0, 4'b0101, 32'h00012345,   32'h00000100,   32'h01234500,   1'b1, "mul2"});
        vecs.push_back('{1'b0, 4'b0110, 32'd100,        32'd7,          32'd14,         1'b1, "divu"});
        vecs.push_back('{1'b0, 4'b0111, 32'd100,        32'd7,          32'd2,          1'b1, "remu"});
        vecs.push_back('{1'b0, 4'b0110, 32'd5,          32'd0,          32'hFFFFFFFF,   1'b1, "divu_b0"});
        vecs.push_back('{1'b0, 4'b0111, 32'd123,        32'd0,          32'd123,        1'b1, "remu_b0"});
        vecs.push_back('{1'b0, 4'b0110, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b1, "divu_max"});
        vecs.push_back('{1'b0, 4'b0111, 32'hFFFFFFFF,   32'h10,         32'hF,          1'b1, "remu_max"});
        vecs.push_back('{1'b0, 4'b1111, 32'd7,          32'd5,          32'd0,          1'b0, "illegal_f"});
        vecs.push_back('{1'b0, 4'b1001, 32'd7,          32'd5,          32'd0,          1'b0, "illegal_9"});
        vecs.push_back('{1'b1, 4'b0010, 32'd7,          32'd5,          32'd12,         1'b1, "add8"});
        vecs.push_back('{1'b1, 4'b0010, 32'd200,        32'd100,        32'd44,         1'b1, "add8_wrap"});
        vecs.push_back('{1'b1, 4'b0100, 32'd3,          32'd9,          32'd0,          1'b1, "sub8_sat"});
        vecs.push_back('{1'b1, 4'b0011, 32'd1,          32'd8,          32'd0,          1'b1, "sll8_8"});
        vecs.push_back('{1'b1, 4'b0011, 32'd1,          32'd7,          32'h80,         1'b1, "sll8_7"});
        vecs.push_back('{1'b1, 4'b0101, 32'h0F,         32'h11,         32'hFF,         1'b1, "mul8"});
        vecs.push_back('{1'b1, 4'b0101, 32'd20,         32'd20,         32'd144,        1'b1, "mul8_wrap"});
        vecs.push_back('{1'b1, 4'b0110, 32'd100,        32'd7,          32'd14,         1'b1, "divu8"});
        vecs.push_back('{1'b1, 4'b0111, 32'd100,        32'd7,          32'd2,          1'b1, "remu8"});
        vecs.push_back('{1'b1, 4'b0110, 32'd100,        32'd0,          32'hFF,         1'b1, "divu8_b0"});
        vecs.push_back('{1'b1, 4'b0111, 32'd100,        32'd0,          32'd100,        1'b1, "remu8_b0"});
        vecs.push_back('{1'b1, 4'b1111, 32'd1,          32'd2,          32'd0,          1'b0, "illegal8"});

        rst_n     = 1'b0;
        sel8      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        code      = 4'd0;
        a         = 32'd0;
        b         = 32'd0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sel8 = (w == 1);
            #1;
            check("reset in_ready", 32'(mon_in_ready), 32'd1);
            check("reset out_valid", 32'(mon_out_valid), 32'd0);
            check("reset result", mon_result, 32'd0);
            check("reset zero", 32'(mon_zero), 32'd0);
            check("reset reg_write", 32'(mon_rw), 32'd0);
        end
        sel8  = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].w8, vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].res,
                  vecs[i].rw, vecs[i].name, (i % 2) == 1, 0);
        end

        // Consumer stalls for five cycles in DONE, for an iterative and an illegal op.
        do_op(1'b0, 4'b0110, 32'd100, 32'd7, 32'd14, 1'b1, "divu_hold", 1'b0, 5);
        do_op(1'b0, 4'b1111, 32'd9,   32'd9, 32'd0,  1'b0, "illegal_hold", 1'b0, 5);
        do_op(1'b0, 4'b0010, 32'd40,  32'd2, 32'd42, 1'b1, "add_pre_rst", 1'b0, 0);

        // Reset lands in the middle of a MUL; nothing may emerge for it.
        @(negedge clk);
        sel8     = 1'b0;
        code     = 4'b0101;
        a        = 32'h0000FFFF;
        b        = 32'h00010001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_mul busy", 32'(mon_in_ready), 32'd0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst out_valid", 32'(mon_out_valid), 32'd0);
        check("mid_rst in_ready", 32'(mon_in_ready), 32'd1);
        check("mid_rst result", mon_result, 32'd0);
        $display("op mid_mul_rst  in_ready=%0d out_valid=%0d", mon_in_ready, mon_out_valid);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            total++;
            if (mon_out_valid !== 1'b0) begin
                bad++;
                $display("FAIL post_rst_ghost: got out_valid=%b want 0", mon_out_valid);
            end
        end
        do_op(1'b0, 4'b0010, 32'd7, 32'd5, 32'd12, 1'b1, "add_post_rst", 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
